// File: rtl/map_arbiter.sv
// map_arbiter: shares one map_rom between wall_tracer (port A) and map_overlay (port B).
//
// Each access is two cycles: IDLE registers the winning address onto o_map_col/o_map_row,
// FETCH samples the combinational ROM output, and the ack cycle (an IDLE cycle) presents
// x_ack=1 with x_val. Overlay (B) wins contested cycles unless the tracer has waited
// MAX_WAIT or more cycles.
//
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   frame_start            vsync pulse; clears wait counter and statistics
//   a_req/a_col/a_row      tracer request and address (hold until a_ack)
//   a_ack/a_val            tracer ack pulse and held map value
//   b_req/b_col/b_row      overlay request and address (hold until b_ack)
//   b_ack/b_val            overlay ack pulse and held map value
//   o_map_col/o_map_row    registered address to map_rom
//   i_map_val              combinational map_rom output
//   o_busy                 high while in FETCH
//   o_conflicts            contested IDLE-cycle count, saturating at 255
//
// Build option: define MAP_ARB_STATS_EN to add o_conflicts and its counter.
module map_arbiter #(
  parameter int unsigned MAP_WIDTH_BITS  = 4,
  parameter int unsigned MAP_HEIGHT_BITS = 4,
  parameter int unsigned MAX_WAIT        = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       frame_start,
  input  logic                       a_req,
  input  logic [MAP_WIDTH_BITS-1:0]  a_col,
  input  logic [MAP_HEIGHT_BITS-1:0] a_row,
  output logic                       a_ack,
  output logic                       a_val,
  input  logic                       b_req,
  input  logic [MAP_WIDTH_BITS-1:0]  b_col,
  input  logic [MAP_HEIGHT_BITS-1:0] b_row,
  output logic                       b_ack,
  output logic                       b_val,
  output logic [MAP_WIDTH_BITS-1:0]  o_map_col,
  output logic [MAP_HEIGHT_BITS-1:0] o_map_row,
  input  logic                       i_map_val,
`ifdef MAP_ARB_STATS_EN
  output logic [7:0]                 o_conflicts,
`endif
  output logic                       o_busy
);

  typedef enum logic [0:0] {StIdle, StFetch} state_e;

  state_e     state_q;
  logic       gnt_b_q;  // port owning the current FETCH (1 = B)
  logic [3:0] wait_q;

  logic pick_a, pick_b, a_starved, a_inc;

  // B wins a contested cycle unless A has starved long enough.
  always_comb begin
    a_starved = 32'(wait_q) >= MAX_WAIT;
    pick_b    = b_req && !(a_req && a_starved);
    pick_a    = a_req && !pick_b;
    // A is waiting whenever it requests but is neither being granted nor being served.
    if (state_q == StIdle) a_inc = a_req && !pick_a;
    else                   a_inc = a_req && gnt_b_q;
  end

  assign o_busy = (state_q == StFetch);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      gnt_b_q   <= 1'b0;
      wait_q    <= 4'd0;
      a_ack     <= 1'b0;
      a_val     <= 1'b0;
      b_ack     <= 1'b0;
      b_val     <= 1'b0;
      o_map_col <= '0;
      o_map_row <= '0;
`ifdef MAP_ARB_STATS_EN
      o_conflicts <= 8'd0;
`endif
    end else begin
      a_ack <= 1'b0;
      b_ack <= 1'b0;

      if (frame_start) begin
        wait_q <= 4'd0;
      end else if (state_q == StIdle && pick_a) begin
        wait_q <= 4'd0;
      end else if (a_inc && wait_q != 4'd15) begin
        wait_q <= wait_q + 4'd1;
      end

`ifdef MAP_ARB_STATS_EN
      if (frame_start) begin
        o_conflicts <= 8'd0;
      end else if (state_q == StIdle && a_req && b_req && o_conflicts != 8'd255) begin
        o_conflicts <= o_conflicts + 8'd1;
      end
`endif

      case (state_q)
        StIdle: begin
          if (a_req || b_req) begin
            gnt_b_q   <= pick_b;
            o_map_col <= pick_b ? b_col : a_col;
            o_map_row <= pick_b ? b_row : a_row;
            state_q   <= StFetch;
          end
        end
        StFetch: begin
          // The ack is issued even if the requester dropped req mid-fetch.
          if (gnt_b_q) begin
            b_val <= i_map_val;
            b_ack <= 1'b1;
          end else begin
            a_val <= i_map_val;
            a_ack <= 1'b1;
          end
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
